// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding and default sizing for the GCD host sequencer
package gcd_pkg;
    localparam int GCD_W = 4;
    localparam int GCD_TIMEOUT = 63;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
endpackage

// File: rtl/gcd_host_if.sv
// gcd_host_if: upstream operand, core and downstream result signals of gcd_host
interface gcd_host_if import gcd_pkg::*; #(parameter int W = GCD_W);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         core_start;
    logic [W-1:0] core_a;
    logic [W-1:0] core_b;
    logic         core_done;
    logic [W-1:0] core_res;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic         out_err;
    modport slave (
        input  in_valid, in_a, in_b, core_done, core_res, out_ready,
        output in_ready, core_start, core_a, core_b, out_valid, out_res, out_err
    );
    modport master (
        output in_valid, in_a, in_b, core_done, core_res, out_ready,
        input  in_ready, core_start, core_a, core_b, out_valid, out_res, out_err
    );
endinterface

// File: rtl/gcd_timeout_cnt.sv
// gcd_timeout_cnt: clear/enable cycle counter flagging its LIMIT-th enabled cycle
module gcd_timeout_cnt import gcd_pkg::*; #(
    parameter int LIMIT = GCD_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term
);
    localparam int CW = $clog2(LIMIT + 1);
    logic [CW-1:0] cnt;
    assign term = cnt == CW'(LIMIT - 1);
    // count enabled cycles, parking on the terminal value until cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && !term) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/gcd_host.sv
// gcd_host: sequences operand pairs through the GCD core, resolving zero operands locally.
// Define GCD_HOST_TIMEOUT_EN to bound the wait for core_done to TIMEOUT cycles.
module gcd_host import gcd_pkg::*; #(
    parameter int W = GCD_W,
    parameter int TIMEOUT = GCD_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    gcd_host_if.slave  bus
);
    state_t st, nxt;
    logic   tmo;
    logic   acc;
    logic   zero_a;
    logic   zero_b;
    if (W < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("gcd_host: W and TIMEOUT must both be at least 1");
    end
    assign acc = st == IDLE && bus.in_valid;
    assign zero_a = bus.in_a == '0;
    assign zero_b = bus.in_b == '0;
    assign bus.in_ready = st == IDLE;
    assign bus.core_start = st == ISSUE;
    assign bus.out_valid = st == HOLD;
`ifdef GCD_HOST_TIMEOUT_EN
    logic term;
    gcd_timeout_cnt #(.LIMIT(TIMEOUT)) u_tmo (
        .clk (clk),
        .rst (rst),
        .clr (st == ISSUE),
        .en  (st == WAIT),
        .term(term)
    );
    assign tmo = term && st == WAIT;
`else
    assign tmo = 1'b0;
`endif
    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= IDLE;
        else st <= nxt;
    end
    // next state: zero operands skip the core entirely
    always_comb begin
        nxt = st;
        unique case (st)
            IDLE:  if (bus.in_valid) nxt = (zero_a || zero_b) ? HOLD : ISSUE;
            ISSUE: nxt = WAIT;
            WAIT:  if (bus.core_done || tmo) nxt = HOLD;
            HOLD:  if (bus.out_ready) nxt = IDLE;
        endcase
    end
    // operand latch and result capture; core_done takes priority over timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.core_a  <= '0;
            bus.core_b  <= '0;
            bus.out_res <= '0;
            bus.out_err <= 1'b0;
        end else if (acc) begin
            bus.core_a  <= bus.in_a;
            bus.core_b  <= bus.in_b;
            if (zero_a || zero_b) begin
                bus.out_res <= zero_a ? bus.in_b : bus.in_a;
                bus.out_err <= zero_a && zero_b;
            end
        end else if (st == WAIT && bus.core_done) begin
            bus.out_res <= bus.core_res;
            bus.out_err <= 1'b0;
        end else if (tmo) begin
            bus.out_res <= '0;
            bus.out_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_gcd_host.sv
// tb_gcd_host: directed self-checking bench for gcd_host
module tb_gcd_host;
    import gcd_pkg::*;
    localparam int W = 4;
    localparam int TIMEOUT = 63;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;
    gcd_host_if #(.W(W)) bus();
    gcd_host #(.W(W), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_a = a;
        bus.in_b = b;
        bus.in_valid = 1'b1;
        chk("acc_in_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic zero_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] res, input logic err);
        accept(a, b);
        chk("zero_valid", bus.out_valid, 1);
        chk("zero_start", bus.core_start, 0);
        chk("zero_res", bus.out_res, res);
        chk("zero_err", bus.out_err, err);
        chk("zero_in_ready", bus.in_ready, 0);
        @(negedge clk);
        chk("zero_back_idle", bus.in_ready, 1);
        chk("zero_valid_drop", bus.out_valid, 0);
    endtask

    task automatic rst_pulse();
        #2 rst = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_start", bus.core_start, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_err", bus.out_err, 0);
        chk("rst_core_a", bus.core_a, 0);
        chk("rst_res", bus.out_res, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.core_done = 1'b0;
        bus.core_res = '0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_start", bus.core_start, 0);
        chk("reset_valid", bus.out_valid, 0);
        chk("reset_err", bus.out_err, 0);
        chk("reset_core_a", bus.core_a, 0);
        chk("reset_core_b", bus.core_b, 0);
        chk("reset_res", bus.out_res, 0);
        rst = 1'b1;
        @(negedge clk);
        accept(4'd12, 4'd8);
        chk("n_start", bus.core_start, 1);
        chk("n_core_a", bus.core_a, 12);
        chk("n_core_b", bus.core_b, 8);
        repeat (4) begin
            @(negedge clk);
            chk("n_start_once", bus.core_start, 0);
            chk("n_wait_valid", bus.out_valid, 0);
        end
        @(negedge clk);
        bus.core_done = 1'b1;
        bus.core_res = 4'd4;
        chk("n_done_cycle_valid", bus.out_valid, 0);
        @(negedge clk);
        bus.core_done = 1'b0;
        chk("n_valid", bus.out_valid, 1);
        chk("n_res", bus.out_res, 4);
        chk("n_err", bus.out_err, 0);
        @(negedge clk);
        chk("n_idle", bus.in_ready, 1);
        chk("n_valid_drop", bus.out_valid, 0);
        zero_pair(4'd0, 4'd9, 4'd9, 1'b0);
        zero_pair(4'd7, 4'd0, 4'd7, 1'b0);
        zero_pair(4'd0, 4'd0, 4'd0, 1'b1);
        zero_pair(4'd0, 4'd3, 4'd3, 1'b0);
        bus.out_ready = 1'b0;
        accept(4'd15, 4'd5);
        chk("bp_start", bus.core_start, 1);
        @(negedge clk);
        bus.core_done = 1'b1;
        bus.core_res = 4'd5;
        @(negedge clk);
        bus.core_done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a = 4'd3;
        bus.in_b = 4'd3;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_res", bus.out_res, 5);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_core_a", bus.core_a, 15);
            @(negedge clk);
        end
        chk("bp_valid_end", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp_next_start", bus.core_start, 1);
        chk("bp_next_core_a", bus.core_a, 3);
        bus.core_done = 1'b1;
        bus.core_res = 4'd9;
        @(negedge clk);
        bus.core_done = 1'b0;
        chk("issue_done_ignored", bus.out_valid, 0);
        @(negedge clk);
        chk("issue_done_still_wait", bus.out_valid, 0);
        bus.core_done = 1'b1;
        bus.core_res = 4'd3;
        @(negedge clk);
        bus.core_done = 1'b0;
        chk("bp_next_valid", bus.out_valid, 1);
        chk("bp_next_res", bus.out_res, 3);
        @(negedge clk);
        accept(4'd4, 4'd6);
`ifdef GCD_HOST_TIMEOUT_EN
        for (int i = 2; i <= 64; i++) begin
            @(negedge clk);
            chk("tmo_waiting", bus.out_valid, 0);
        end
        @(negedge clk);
        chk("tmo_valid", bus.out_valid, 1);
        chk("tmo_res", bus.out_res, 0);
        chk("tmo_err", bus.out_err, 1);
        @(negedge clk);
        chk("tmo_idle", bus.in_ready, 1);
        accept(4'd8, 4'd12);
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_wait", bus.out_valid, 0);
        rst_pulse();
`else
        repeat (200) begin
            @(negedge clk);
            chk("hang_valid", bus.out_valid, 0);
            chk("hang_in_ready", bus.in_ready, 0);
        end
        rst_pulse();
`endif
        accept(4'd9, 4'd6);
        chk("post_rst_start", bus.core_start, 1);
        @(negedge clk);
        bus.core_done = 1'b1;
        bus.core_res = 4'd3;
        @(negedge clk);
        bus.core_done = 1'b0;
        chk("post_rst_valid", bus.out_valid, 1);
        chk("post_rst_res", bus.out_res, 3);
        chk("post_rst_err", bus.out_err, 0);
        @(negedge clk);
        chk("post_rst_idle", bus.in_ready, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gcd_host.md
# gcd_host

Host-side sequencer for the GCD core. It accepts operand pairs from an upstream valid/ready source and issues each pair to the core with a one-cycle `core_start` pulse. It waits for `core_done`, then returns the result downstream on a valid/ready interface. Zero operands are resolved locally, because the core's subtract loop never terminates on them.

## Interface
Parameters:
- `W`, default 4: operand and result width.
- `TIMEOUT`, default 63: WAIT-state cycle limit. Used only when the timeout feature is compiled in.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operand pair valid.
- `in_ready`  out  1: block can accept a pair.
- `in_a`, `in_b`  in  W: operands.
- `core_start`  out  1: one-cycle start pulse to the core.
- `core_a`, `core_b`  out  W: registered operands driven to the core.
- `core_done`  in  1: core result valid, one cycle.
- `core_res`  in  W: core result.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: downstream accepts the result.
- `out_res`  out  W: result.
- `out_err`  out  1: both operands zero, or timeout.

## Operation
- States: IDLE, ISSUE, WAIT, HOLD.
- `in_ready` = (state == IDLE).
- **IDLE**: on `in_valid`, latch `in_a`/`in_b` into `core_a`/`core_b`, then:
  - both zero: `out_res` = 0, `out_err` = 1, go to HOLD.
  - `in_a` == 0: `out_res` = `in_b`, go to HOLD.
  - `in_b` == 0: `out_res` = `in_a`, go to HOLD.
  - otherwise: go to ISSUE.
- **ISSUE**: `core_start` = 1 for this cycle only. Go to WAIT unconditionally.
- **WAIT**: on `core_done`, capture `core_res` into `out_res`, set `out_err` = 0, go to HOLD. `core_done` is ignored in every other state.
- **HOLD**: `out_valid` = 1. `out_res` and `out_err` are held stable until `out_valid` && `out_ready`, then go to IDLE.
- `core_a`/`core_b` stay stable from the accept cycle until the next accept.
- Results are delivered strictly in order. Only one operation is ever outstanding.

## Timing
- Reset values:
  - state IDLE, so `in_ready` = 1.
  - `core_start` = 0, `out_valid` = 0, `out_err` = 0.
  - `core_a`, `core_b`, `out_res` = 0.
- Normal path: accept at cycle 0, `core_start` at cycle 1. If `core_done` arrives at cycle k (k ≥ 2), `out_valid` rises at cycle k+1.
- Zero-operand path: accept at cycle 0, `out_valid` at cycle 1. `core_start` never asserts.
- Handshake completes at cycle h: IDLE at h+1, so `in_ready` = 1 at h+1. There is no same-cycle bypass, so the minimum initiation interval is 2 cycles on the zero path.
- `core_done` arriving in ISSUE is not sampled (the core needs at least one cycle).
- `rst` asserted at any time, including mid-WAIT: all outputs go to reset values immediately. The core is reset by the same `rst`. The in-flight pair is discarded.

## Configuration
- `GCD_HOST_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT` without `core_done`, go to HOLD with `out_res` = 0, `out_err` = 1.
  - If `core_done` arrives in the same cycle the limit is reached, `core_done` wins.
- `GCD_HOST_TIMEOUT_EN` undefined: WAIT persists until `core_done`. `out_err` is set only for the both-zero case. No counter logic is synthesized.

## Structure
- Shared package `gcd_pkg`:
  - state enum (IDLE/ISSUE/WAIT/HOLD).
  - default width constant (4).
  - default timeout constant (63).
- One natural sub-module, `gcd_timeout_cnt`: a clear/enable counter with a terminal flag. Instantiated only under `GCD_HOST_TIMEOUT_EN`.

## Test plan
- (12, 8), core model returns 4 with `core_done` 5 cycles after `core_start` → `out_res` = 4, `out_err` = 0, `out_valid` the cycle after `core_done`.
- (0, 9) → `out_res` = 9 at cycle 1 after accept, `out_err` = 0, no `core_start` pulse. Repeat with (7, 0) → `out_res` = 7.
- (0, 0) → `out_res` = 0, `out_err` = 1, no `core_start`.
- (15, 5) result ready, `out_ready` held low 10 cycles → `out_valid`/`out_res` = 5 stable throughout, `in_ready` = 0, `in_valid` ignored; the pair accepted one cycle after the handshake.
- Timeout build, `TIMEOUT` = 63, core never signals `core_done` → `out_valid` with `out_res` = 0, `out_err` = 1 after 63 WAIT cycles. Non-timeout build stays in WAIT with `out_valid` = 0 for at least 200 cycles.
- `rst` pulsed low during WAIT → `core_start`/`out_valid` = 0 and `in_ready` = 1 immediately. After release, the next pair (9, 6) yields 3.
